// File: rtl/unstripe_deskew_ctrl.sv
// unstripe_deskew_ctrl: two-lane comma-aligned deskew buffer and byte
// reassembler. Each lane feeds a small FIFO. The controller discards bytes
// until both FIFO heads hold the comma, then interleaves lane 0 / lane 1
// bytes onto a single registered output stream.
module unstripe_deskew_ctrl #(
   parameter logic [7:0] COM      = 8'hBC,
   parameter int         DEPTH    = 4,
   parameter int         MAX_SKEW = 6
) (
   input  logic       clk_2f,
   input  logic       reset,
   input  logic [7:0] lane_0,
   input  logic       valid_0,
   input  logic [7:0] lane_1,
   input  logic       valid_1,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       aligned,
   output logic       skew_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(MAX_SKEW + 1);

   localparam logic [1:0] SEARCH  = 2'd0;
   localparam logic [1:0] WAIT    = 2'd1;
   localparam logic [1:0] ALIGNED = 2'd2;

   logic [1:0]    state, next_state;
   logic          sel, next_sel;
   logic          lock, next_lock;
   logic          other;
   logic [SW-1:0] skew_cnt, next_skew;
   logic          timeout;
   logic          err;
   logic [1:0]    pop, nonempty, is_com, full, overflow, push_ok;
   logic [7:0]    head [2];

   genvar g;
   generate
      for (g = 0; g < 2; g++) begin : g_lane
         logic [7:0]    mem [DEPTH];
         logic [AW-1:0] wr_ptr, rd_ptr;
         logic [CW-1:0] cnt;
         logic [7:0]    din;
         logic          vin;

         assign din         = (g == 0) ? lane_0 : lane_1;
         assign vin         = (g == 0) ? valid_0 : valid_1;
         assign head[g]     = mem[rd_ptr];
         assign nonempty[g] = (cnt != '0);
         assign full[g]     = (cnt == CW'(DEPTH));
         assign is_com[g]   = nonempty[g] && (mem[rd_ptr] == COM);
         // A same-edge pop frees the slot, so a full FIFO can still accept.
         assign overflow[g] = vin && full[g] && !pop[g];
         assign push_ok[g]  = vin && (!full[g] || pop[g]) && !err;

         // Storage write; contents need no reset because cnt gates visibility.
         always_ff @(posedge clk_2f) begin
            if (push_ok[g]) mem[wr_ptr] <= din;
         end

         // Pointer/occupancy update, flushed on reset or any error event.
         always_ff @(posedge clk_2f or negedge reset) begin
            if (!reset) begin
               wr_ptr <= '0;
               rd_ptr <= '0;
               cnt    <= '0;
            end else if (err) begin
               wr_ptr <= '0;
               rd_ptr <= '0;
               cnt    <= '0;
            end else begin
               if (push_ok[g]) wr_ptr <= wr_ptr + AW'(1);
               if (pop[g])     rd_ptr <= rd_ptr + AW'(1);
               if (push_ok[g] && !pop[g])      cnt <= cnt + CW'(1);
               else if (!push_ok[g] && pop[g]) cnt <= cnt - CW'(1);
            end
         end
      end
   endgenerate

   assign err = (|overflow) | timeout;

   // Next-state, pop selection and skew timeout for the alignment FSM.
   always_comb begin
      pop        = '0;
      next_state = state;
      next_sel   = sel;
      next_lock  = lock;
      next_skew  = skew_cnt;
      timeout    = 1'b0;
      other      = ~lock;
      case (state)
         SEARCH: begin
            pop = nonempty & ~is_com;
            if (&is_com) begin
               next_state = ALIGNED;
               next_sel   = 1'b0;
            end else if (|is_com) begin
               next_state = WAIT;
               next_lock  = is_com[1];
               next_skew  = '0;
            end
         end
         WAIT: begin
            // A comma arriving on the other lane wins over the timeout.
            if (is_com[other]) begin
               next_state = ALIGNED;
               next_sel   = 1'b0;
            end else begin
               pop[other] = nonempty[other];
               if (skew_cnt == SW'(MAX_SKEW)) timeout = 1'b1;
               else                           next_skew = skew_cnt + SW'(1);
            end
         end
         ALIGNED: begin
            pop[sel] = nonempty[sel];
            if (nonempty[sel]) next_sel = ~sel;
         end
         default: next_state = SEARCH;
      endcase
   end

   // Control state and registered outputs.
   always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
         state     <= SEARCH;
         sel       <= 1'b0;
         lock      <= 1'b0;
         skew_cnt  <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
         aligned   <= 1'b0;
         skew_err  <= 1'b0;
      end else if (err) begin
         state     <= SEARCH;
         sel       <= 1'b0;
         lock      <= 1'b0;
         skew_cnt  <= '0;
         valid_out <= 1'b0;
         aligned   <= 1'b0;
         skew_err  <= 1'b1;
      end else begin
         state     <= next_state;
         sel       <= next_sel;
         lock      <= next_lock;
         skew_cnt  <= next_skew;
         aligned   <= (next_state == ALIGNED);
         skew_err  <= 1'b0;
         valid_out <= (state == ALIGNED) && nonempty[sel];
         if ((state == ALIGNED) && nonempty[sel]) data_out <= head[sel];
      end
   end

endmodule

// File: tb/tb_unstripe_deskew_ctrl.sv
// tb_unstripe_deskew_ctrl: directed scenarios with a scoreboard queue of
// expected output bytes, drained by an independent output monitor.
module tb_unstripe_deskew_ctrl;

   logic       clk_2f = 1'b0;
   logic       reset  = 1'b0;
   logic [7:0] lane_0 = '0;
   logic       valid_0 = 1'b0;
   logic [7:0] lane_1 = '0;
   logic       valid_1 = 1'b0;
   logic [7:0] data_out;
   logic       valid_out;
   logic       aligned;
   logic       skew_err;

   logic [7:0] exp_q [$];
   int total   = 0;
   int bad     = 0;
   int err_cnt = 0;
   int e0;

   unstripe_deskew_ctrl #(.COM(8'hBC), .DEPTH(4), .MAX_SKEW(6)) dut (
      .clk_2f   (clk_2f),
      .reset    (reset),
      .lane_0   (lane_0),
      .valid_0  (valid_0),
      .lane_1   (lane_1),
      .valid_1  (valid_1),
      .data_out (data_out),
      .valid_out(valid_out),
      .aligned  (aligned),
      .skew_err (skew_err)
   );

   always #5 clk_2f = ~clk_2f;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock of stimulus: inputs applied now, sampled by the next rising edge.
   task automatic cyc(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
      valid_0 = v0;
      lane_0  = d0;
      valid_1 = v1;
      lane_1  = d1;
      @(posedge clk_2f);
      #1;
      valid_0 = 1'b0;
      valid_1 = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic expect4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
      exp_q.push_back(a);
      exp_q.push_back(b);
      exp_q.push_back(c);
      exp_q.push_back(d);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) idle(1);
      idle(3);
      chk(name, exp_q.size(), 0);
   endtask

   // Output monitor: counts error pulses and checks each valid byte in order.
   initial begin : monitor
      logic [7:0] e;
      forever begin
         @(negedge clk_2f);
         if (reset) begin
            if (skew_err) err_cnt++;
            if (valid_out) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_out: got %02h expected none", data_out);
               end else begin
                  e = exp_q.pop_front();
                  chk("data_out", data_out, e);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [7:0] b;
      // Reset state
      #12;
      chk("rst_data_out", data_out, 8'h00);
      chk("rst_valid_out", valid_out, 1'b0);
      chk("rst_aligned", aligned, 1'b0);
      chk("rst_skew_err", skew_err, 1'b0);
      reset = 1'b1;

      // Zero skew, first push on the first edge after release
      expect4(8'hBC, 8'hBC, 8'h01, 8'h02);
      exp_q.push_back(8'h03);
      exp_q.push_back(8'h04);
      cyc(1'b1, 8'hBC, 1'b1, 8'hBC);
      cyc(1'b1, 8'h01, 1'b1, 8'h02);
      cyc(1'b1, 8'h03, 1'b1, 8'h04);
      drain("zero_skew_drain");
      chk("zero_skew_aligned", aligned, 1'b1);
      chk("zero_skew_no_err", err_cnt, 0);

      // Lane 1 stalls; lane 0 fills its FIFO and the fifth stalled push overflows
      exp_q.push_back(8'h05);
      cyc(1'b1, 8'h05, 1'b0, 8'h00);
      idle(3);
      chk("stall_valid_out", valid_out, 1'b0);
      chk("stall_aligned", aligned, 1'b1);
      e0 = err_cnt;
      for (int i = 0; i < 4; i++) begin
         b = 8'h06 + 8'(i);
         cyc(1'b1, b, 1'b0, 8'h00);
      end
      chk("ovf_not_yet", skew_err, 1'b0);
      cyc(1'b1, 8'h0A, 1'b0, 8'h00);
      chk("ovf_pulse", skew_err, 1'b1);
      idle(4);
      chk("ovf_err_count", err_cnt - e0, 1);
      chk("ovf_aligned", aligned, 1'b0);
      chk("ovf_queue", exp_q.size(), 0);

      // Lane 0 comma, lane 1 silent: timeout exactly at skew_cnt == MAX_SKEW
      e0 = err_cnt;
      cyc(1'b1, 8'hBC, 1'b0, 8'h00);
      idle(7);
      chk("to_early", skew_err, 1'b0);
      chk("to_wait_aligned", aligned, 1'b0);
      idle(1);
      chk("to_pulse", skew_err, 1'b1);
      idle(5);
      chk("to_err_count", err_cnt - e0, 1);
      chk("to_aligned", aligned, 1'b0);

      // Lane 1 lags by two garbage bytes
      e0 = err_cnt;
      expect4(8'hBC, 8'hBC, 8'h01, 8'h02);
      exp_q.push_back(8'h03);
      exp_q.push_back(8'h04);
      cyc(1'b1, 8'hBC, 1'b1, 8'h55);
      cyc(1'b1, 8'h01, 1'b1, 8'hAA);
      chk("lag_wait_aligned", aligned, 1'b0);
      cyc(1'b1, 8'h03, 1'b1, 8'hBC);
      cyc(1'b0, 8'h00, 1'b1, 8'h02);
      cyc(1'b0, 8'h00, 1'b1, 8'h04);
      drain("lag_drain");
      chk("lag_aligned", aligned, 1'b1);
      chk("lag_no_err", err_cnt - e0, 0);

      // Reset mid-ALIGNED with bytes still buffered
      expect4(8'hBC, 8'hBC, 8'h01, 8'h02);
      exp_q.push_back(8'h03);
      exp_q.push_back(8'h04);
      cyc(1'b1, 8'hBC, 1'b1, 8'hBC);
      cyc(1'b1, 8'h01, 1'b1, 8'h02);
      cyc(1'b1, 8'h03, 1'b1, 8'h04);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_data_out", data_out, 8'h00);
      chk("mid_rst_valid_out", valid_out, 1'b0);
      chk("mid_rst_aligned", aligned, 1'b0);
      chk("mid_rst_skew_err", skew_err, 1'b0);
      exp_q.delete();
      @(posedge clk_2f);
      #3;
      reset = 1'b1;
      expect4(8'hBC, 8'hBC, 8'h11, 8'h22);
      cyc(1'b1, 8'hBC, 1'b1, 8'hBC);
      cyc(1'b1, 8'h11, 1'b1, 8'h22);
      drain("realign_drain");
      chk("realign_aligned", aligned, 1'b1);

      // Lane 1 comma lands on the cycle the WAIT timeout would fire
      @(negedge clk_2f);
      reset = 1'b0;
      @(posedge clk_2f);
      #2;
      reset = 1'b1;
      e0 = err_cnt;
      expect4(8'hBC, 8'hBC, 8'h01, 8'h02);
      cyc(1'b1, 8'hBC, 1'b0, 8'h00);
      idle(6);
      cyc(1'b0, 8'h00, 1'b1, 8'hBC);
      cyc(1'b1, 8'h01, 1'b1, 8'h02);
      drain("edge_drain");
      chk("edge_no_err", err_cnt - e0, 0);
      chk("edge_aligned", aligned, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
